resp_fifo_sync: RTL and testbench
=================================

// Module: resp_fifo_sync
// PURPOSE
//  Single-clock, parametrised response FIFO for the UART-to-APB bridge: buffers APB read data/status
//  toward the UART TX path when both sides share one clock domain. Successor to the dual-clock
//  response FIFO: adds configurable depth/width, occupancy count, almost-full/almost-empty
//  thresholds, sticky overflow/underflow error flags, synchronous flush and a first-word-fall-through mode.
// PARAMETERS
//  WIDTH     32   data word width in bits
//  ADDRBITS  4    log2 of depth; DEPTH = 2**ADDRBITS (ADDRBITS >= 1)
//  AF_THRESH 14   afull asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH 2    aempty asserted when count <= AE_THRESH (0..DEPTH-1)
//  FWFT      0    0 = registered read (data 1 cycle after ren); 1 = show-ahead head word
// PORTS
//  clk      in   1           single clock, all logic on rising edge
//  reset    in   1           synchronous, active-high reset
//  flush    in   1           synchronous clear of pointers/count (mem contents not cleared)
//  wdata    in   WIDTH       write data
//  wen      in   1           write request
//  ren      in   1           read request (pop)
//  rdata    out  WIDTH       read data
//  rvalid   out  1           rdata holds a valid popped (FWFT=0) / head (FWFT=1) word
//  eflag    out  1           empty (count == 0)
//  fflag    out  1           full (count == DEPTH)
//  aempty   out  1           count <= AE_THRESH
//  afull    out  1           count >= AF_THRESH
//  count    out  ADDRBITS+1  current occupancy, 0..DEPTH
//  ovf      out  1           sticky: write attempted while full and not popping
//  udf      out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (reset=1 at edge): wptr=rptr=0, count=0, rdata=0, rvalid=0, ovf=0, udf=0;
//    outputs next cycle: eflag=1, fflag=0, aempty=1, afull=0. reset has priority over flush/wen/ren.
//  - Pointers ADDRBITS+1 bits binary, wrap modulo 2*DEPTH; mem index = ptr[ADDRBITS-1:0].
//  - count = wptr - rptr (ADDRBITS+1 bit subtraction); eflag/fflag/aempty/afull decoded from
//    registered count, no combinational path from wen/ren.
//  - Write accepted: wen & (!fflag | ren_acc). Read accepted ren_acc: ren & !eflag.
//  - Full & wen & ren: both accepted, count unchanged, no ovf. Full & wen & !ren: write dropped, ovf<=1.
//  - Empty & ren (with or without wen): read rejected, udf<=1; simultaneous wen still accepted.
//  - Written word readable no earlier than cycle after write (no write-to-read bypass).
//  - FWFT=0: on accepted read rdata<=mem[rptr], rvalid<=1 next cycle; else rvalid<=0, rdata holds.
//  - FWFT=1: rdata = mem[rptr] registered head, rvalid = !eflag; ren pops head, next word appears
//    next cycle. Write into empty FIFO: rvalid rises 1 cycle after write.
//  - flush=1: wptr=rptr=0, count=0, rvalid=0; ovf/udf preserved; wen/ren that cycle ignored.
//  - ovf/udf cleared only by reset.
// STRUCTURE
//  - Shared bridge package: FIFO default WIDTH/ADDRBITS constants, function clog2-free
//    depth calc DEPTH = 1<<ADDRBITS.
//  - One sub-module: resp_fifo_ram (DEPTH x WIDTH, 1 write port, 1 registered read port, single clk);
//    pointer/count/flag logic lives in resp_fifo_sync.
// TESTING (WIDTH=32, ADDRBITS=4, AF_THRESH=14, AE_THRESH=2, both FWFT values)
//  1. Reset then idle -> eflag=1, aempty=1, fflag=0, afull=0, count=0, rvalid=0, rdata=0.
//  2. Write 0x100..0x10F (16 words) -> count 1..16, aempty drops at count 3, afull at 14,
//     fflag at 16; 17th write 0xDEAD -> dropped, ovf=1, count stays 16.
//  3. Drain 16 reads -> data 0x100..0x10F in order (FWFT=0: 1-cycle latency); extra read -> udf=1,
//     eflag=1, rvalid low.
//  4. Full + wen&ren same cycle -> count stays 16, no ovf; popped word = oldest, new word last out.
//  5. Wrap: 40 interleaved write/read pairs at count 3 -> data order preserved across pointer wrap.
//  6. Flush at count 9 with wen=1 -> count=0, eflag=1, rvalid=0, ovf/udf unchanged; reset mid-burst
//     -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/resp_fifo_sync_pkg.sv
// resp_fifo_sync_pkg: shared bridge FIFO defaults and depth helper
package resp_fifo_sync_pkg;
    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_ADDRBITS = 4;
    function automatic int unsigned fifo_depth(input int unsigned addrbits);
        return 32'd1 << addrbits;
    endfunction
endpackage

// File: rtl/resp_fifo_sync_if.sv
// resp_fifo_sync_if: write/read/status bundle of the single-clock response FIFO
interface resp_fifo_sync_if import resp_fifo_sync_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int ADDRBITS = FIFO_ADDRBITS
);
    logic flush, wen, ren, rvalid, eflag, fflag, aempty, afull, ovf, udf;
    logic [WIDTH-1:0] wdata, rdata;
    logic [ADDRBITS:0] count;
    modport master(
        output flush, wdata, wen, ren,
        input rdata, rvalid, eflag, fflag, aempty, afull, count, ovf, udf
    );
    modport slave(
        input flush, wdata, wen, ren,
        output rdata, rvalid, eflag, fflag, aempty, afull, count, ovf, udf
    );
endinterface

// File: rtl/resp_fifo_ram.sv
// resp_fifo_ram: DEPTH x WIDTH storage, one write port, one registered read port
module resp_fifo_ram import resp_fifo_sync_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int ADDRBITS = FIFO_ADDRBITS,
    parameter bit FWD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                re,
    input  logic [ADDRBITS-1:0] waddr,
    input  logic [ADDRBITS-1:0] raddr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata
);
    logic [WIDTH-1:0] mem [fifo_depth(ADDRBITS)];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= (FWD && we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/resp_fifo_sync.sv
// resp_fifo_sync: single-clock response FIFO with flags, sticky errors, flush and optional FWFT
module resp_fifo_sync import resp_fifo_sync_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int ADDRBITS = FIFO_ADDRBITS,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT = 0
) (
    input logic clk,
    input logic reset,
    resp_fifo_sync_if.slave bus
);
    localparam logic [ADDRBITS:0] DEPTH = (ADDRBITS+1)'(fifo_depth(ADDRBITS));
    localparam logic [ADDRBITS:0] AF = (ADDRBITS+1)'(AF_THRESH);
    localparam logic [ADDRBITS:0] AE = (ADDRBITS+1)'(AE_THRESH);
    localparam bit SHOW = (FWFT != 0);
    logic [ADDRBITS:0] wptr, rptr, rptr_n;
    logic ren_acc, wen_acc, rv_q, ovf_q, udf_q;
    always_comb begin
        ren_acc = bus.ren && !bus.eflag && !bus.flush;
        wen_acc = bus.wen && (!bus.fflag || ren_acc) && !bus.flush;
        rptr_n = rptr + (ADDRBITS+1)'(ren_acc);
    end
    always_ff @(posedge clk)
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            rv_q <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            rv_q <= 1'b0;
        end else begin
            wptr <= wptr + (ADDRBITS+1)'(wen_acc);
            rptr <= rptr_n;
            rv_q <= ren_acc;
            ovf_q <= ovf_q | (bus.wen & bus.fflag & !ren_acc);
            udf_q <= udf_q | (bus.ren & bus.eflag);
        end
    assign bus.count = wptr - rptr;
    assign bus.eflag = bus.count == '0;
    assign bus.fflag = bus.count == DEPTH;
    assign bus.aempty = bus.count <= AE;
    assign bus.afull = bus.count >= AF;
    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
    assign bus.rvalid = SHOW ? !bus.eflag : rv_q;
    resp_fifo_ram #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS), .FWD(SHOW)) ram (
        .clk(clk),
        .rst(reset),
        .we(wen_acc),
        .re(ren_acc || (SHOW && wen_acc)),
        .waddr(wptr[ADDRBITS-1:0]),
        .raddr(SHOW ? rptr_n[ADDRBITS-1:0] : rptr[ADDRBITS-1:0]),
        .wdata(bus.wdata),
        .rdata(bus.rdata)
    );
endmodule

// File: tb/tb_resp_fifo_sync.sv
// tb_resp_fifo_sync: queue-model checker driving registered-read and FWFT instances in lockstep
module tb_resp_fifo_sync;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [31:0] wdata = '0;
    int tests = 0, fails = 0;
    bit model_on = 1'b0;
    logic [31:0] q[$];
    bit m_ovf, m_udf, m_rv0;
    logic [31:0] m_rd0;
    always #5 clk = ~clk;
    resp_fifo_sync_if #(.WIDTH(32), .ADDRBITS(4)) b0(), b1();
    assign b0.flush = flush;
    assign b0.wen = wen;
    assign b0.ren = ren;
    assign b0.wdata = wdata;
    assign b1.flush = flush;
    assign b1.wen = wen;
    assign b1.ren = ren;
    assign b1.wdata = wdata;
    resp_fifo_sync #(.WIDTH(32), .ADDRBITS(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) d0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    resp_fifo_sync #(.WIDTH(32), .ADDRBITS(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) d1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic cmp_flags(input string t, input logic [4:0] c, input logic e, f, ae, af, ov, ud);
        int n = q.size();
        chk({t, ".count"}, 32'(c), 32'(n));
        chk({t, ".eflag"}, 32'(e), 32'(n == 0));
        chk({t, ".fflag"}, 32'(f), 32'(n == 16));
        chk({t, ".aempty"}, 32'(ae), 32'(n <= 2));
        chk({t, ".afull"}, 32'(af), 32'(n >= 14));
        chk({t, ".ovf"}, 32'(ov), 32'(m_ovf));
        chk({t, ".udf"}, 32'(ud), 32'(m_udf));
    endtask
    task automatic model(input bit w, input logic [31:0] d, input bit r, input bit fl, input bit rs);
        bit ra, wa;
        if (rs) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_rv0 = 0;
            m_rd0 = '0;
            model_on = 1;
        end else if (fl) begin
            q.delete();
            m_rv0 = 0;
        end else begin
            ra = r && q.size() > 0;
            wa = w && (q.size() < 16 || ra);
            if (w && q.size() == 16 && !ra) m_ovf = 1;
            if (r && q.size() == 0) m_udf = 1;
            m_rv0 = ra;
            if (ra) m_rd0 = q.pop_front();
            if (wa) q.push_back(d);
        end
    endtask
    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit fl, input bit rs);
        wen = w;
        wdata = d;
        ren = r;
        flush = fl;
        reset = rs;
        @(posedge clk);
        model(w, d, r, fl, rs);
        #1;
    endtask
    always @(negedge clk)
        if (model_on) begin
            cmp_flags("d0", b0.count, b0.eflag, b0.fflag, b0.aempty, b0.afull, b0.ovf, b0.udf);
            cmp_flags("d1", b1.count, b1.eflag, b1.fflag, b1.aempty, b1.afull, b1.ovf, b1.udf);
            chk("d0.rvalid", 32'(b0.rvalid), 32'(m_rv0));
            chk("d0.rdata", b0.rdata, m_rd0);
            chk("d1.rvalid", 32'(b1.rvalid), 32'(q.size() > 0));
            if (q.size() > 0) chk("d1.rdata", b1.rdata, q[0]);
        end
    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("rst.count", 32'(b0.count), 0);
        chk("rst.eflag", 32'(b0.eflag), 1);
        chk("rst.aempty", 32'(b1.aempty), 1);
        chk("rst.fflag", 32'(b0.fflag), 0);
        chk("rst.afull", 32'(b1.afull), 0);
        chk("rst.rvalid0", 32'(b0.rvalid), 0);
        chk("rst.rvalid1", 32'(b1.rvalid), 0);
        chk("rst.rdata0", b0.rdata, 0);
        chk("rst.rdata1", b1.rdata, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h100 + i, 0, 0, 0);
            chk("fill.count", 32'(b1.count), 32'(i + 1));
            if (i == 1) chk("fill.aempty_at2", 32'(b0.aempty), 1);
            if (i == 2) chk("fill.aempty_at3", 32'(b0.aempty), 0);
            if (i == 12) chk("fill.afull_at13", 32'(b0.afull), 0);
            if (i == 13) chk("fill.afull_at14", 32'(b0.afull), 1);
            if (i == 14) chk("fill.fflag_at15", 32'(b1.fflag), 0);
            if (i == 15) chk("fill.fflag_at16", 32'(b1.fflag), 1);
        end
        chk("fill.head1", b1.rdata, 32'h100);
        step(1, 32'hDEAD, 0, 0, 0);
        chk("ovf.d0", 32'(b0.ovf), 1);
        chk("ovf.d1", 32'(b1.ovf), 1);
        chk("ovf.count", 32'(b0.count), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0);
            chk("drain.d0", b0.rdata, 32'h100 + i);
            if (i < 15) chk("drain.head1", b1.rdata, 32'h101 + i);
        end
        step(0, 0, 1, 0, 0);
        chk("udf.flag", 32'(b0.udf), 1);
        chk("udf.eflag", 32'(b1.eflag), 1);
        chk("udf.rvalid0", 32'(b0.rvalid), 0);
        chk("udf.rvalid1", 32'(b1.rvalid), 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 32'h200 + i, 0, 0, 0);
        step(1, 32'h300, 1, 0, 0);
        chk("fullrw.count", 32'(b0.count), 16);
        chk("fullrw.ovf", 32'(b0.ovf), 0);
        chk("fullrw.pop", b0.rdata, 32'h200);
        chk("fullrw.head1", b1.rdata, 32'h201);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        chk("fullrw.last", b0.rdata, 32'h300);
        for (int i = 0; i < 3; i++) step(1, 32'h400 + i, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 32'h500 + i, 1, 0, 0);
            chk("wrap.count", 32'(b0.count), 3);
            chk("wrap.d0", b0.rdata, i < 3 ? 32'h400 + i : 32'h500 + i - 3);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("wrap.last", b0.rdata, 32'h500 + 39);
        for (int i = 0; i < 9; i++) step(1, 32'h600 + i, 0, 0, 0);
        chk("flush.pre", 32'(b0.count), 9);
        step(1, 32'h777, 1, 1, 0);
        chk("flush.count", 32'(b0.count), 0);
        chk("flush.eflag", 32'(b1.eflag), 1);
        chk("flush.rvalid0", 32'(b0.rvalid), 0);
        chk("flush.rvalid1", 32'(b1.rvalid), 0);
        chk("flush.ovf", 32'(b0.ovf), 0);
        chk("flush.udf", 32'(b0.udf), 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h800 + i, i > 2, 0, 0);
        step(1, 32'h900, 1, 0, 1);
        chk("midrst.count", 32'(b0.count), 0);
        chk("midrst.eflag", 32'(b0.eflag), 1);
        chk("midrst.aempty", 32'(b1.aempty), 1);
        chk("midrst.fflag", 32'(b0.fflag), 0);
        chk("midrst.afull", 32'(b1.afull), 0);
        chk("midrst.rvalid0", 32'(b0.rvalid), 0);
        chk("midrst.rvalid1", 32'(b1.rvalid), 0);
        chk("midrst.rdata0", b0.rdata, 0);
        chk("midrst.rdata1", b1.rdata, 0);
        chk("midrst.udf", 32'(b1.udf), 0);
        step(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
